// File: rtl/serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_adder: bit-serial WIDTH-bit adder built on a single full adder cell. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (c & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int                CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  // Only the upper WIDTH-1 result bits need storage; the last bit goes straight to sum.
  logic [WIDTH-2:0] r_res;
  logic [WIDTH-1:0] w_res_next;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             w_s;
  logic             w_co;
  logic             w_load;
  logic             w_step;
  logic             w_last;

  full_adder u_fa (
    .a  (r_a_sr[0]),
    .b  (r_b_sr[0]),
    .c  (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  assign w_res_next = {w_s, r_res};

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == C_LAST) begin
          w_last       = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      done    <= w_last;
      if (w_load) begin
        r_a_sr  <= a_in;
        r_b_sr  <= b_in;
        r_carry <= cin;
        r_res   <= '0;
        r_cnt   <= '0;
        busy    <= 1'b1;
      end
      if (w_step) begin
        r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
        r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
        r_carry <= w_co;
        r_res   <= w_res_next[WIDTH-1:1];
        // Wrap explicitly so a power-of-two WIDTH never relies on counter overflow.
        r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      end
      if (w_last) begin
        busy <= 1'b0;
        sum  <= w_res_next;
        cout <= w_co;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_serial_adder: directed and random checks of serial_adder (WIDTH 8 and 4).|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps

module tb_serial_adder;
  logic       clk;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  int n_checks;
  int n_fail;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 addition; returns result, edges from accept to done, busy cycles,
  // and whether {cout,sum} strayed from hold_exp before done.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [8:0] hold_exp,
                      output logic [8:0] res, output int lat, output int nbusy,
                      output int hold_bad);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = 0; nbusy = 0; hold_bad = 0;
    while (!done8 && lat < 30) begin
      if (busy8) nbusy++;
      if ({cout8, sum8} !== hold_exp) hold_bad = 1;
      @(posedge clk); #1;
      lat++;
    end
    res = {cout8, sum8};
    @(posedge clk); #1;
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c,
                      output logic [4:0] res, output int lat);
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b; cin4 = c;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    lat = 0;
    while (!done4 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    res = {cout4, sum4};
    @(posedge clk); #1;
  endtask

  logic [8:0] res8, exp8;
  logic [4:0] res4, exp4;
  int         lat, nbusy, hold_bad, seen, ndone, last_done;
  logic       pbusy;
  logic [7:0] da, db, ea, eb;
  logic       dc, ec;

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy", {31'd0, busy8}, 32'd0);
    check_eq("reset_done", {31'd0, done8}, 32'd0);
    check_eq("reset_res",  {23'd0, cout8, sum8}, 32'd0);
    check_eq("reset_res4", {27'd0, cout4, sum4}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // 0 + 0 + 0: timing and busy duration
    run8(8'h00, 8'h00, 1'b0, 9'h000, res8, lat, nbusy, hold_bad);
    check_eq("zero_res",  {23'd0, res8}, 32'h000);
    check_eq("zero_lat",  lat, 32'd8);
    check_eq("zero_busy", nbusy, 32'd8);

    // full ripple
    run8(8'hFF, 8'h01, 1'b0, 9'h000, res8, lat, nbusy, hold_bad);
    check_eq("ripple_res",  {23'd0, res8}, 32'h100);
    check_eq("ripple_hold", hold_bad, 32'd0);

    run8(8'hA5, 8'h5A, 1'b1, 9'h100, res8, lat, nbusy, hold_bad);
    check_eq("a5_5a_res", {23'd0, res8}, 32'h100);
    run8(8'h3C, 8'h42, 1'b0, 9'h100, res8, lat, nbusy, hold_bad);
    check_eq("3c_42_res",  {23'd0, res8}, 32'h07E);
    check_eq("3c_42_hold", hold_bad, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle_held", {23'd0, cout8, sum8}, 32'h07E);

    // reset in the 4th RUN cycle aborts the computation
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_busy", {31'd0, busy8}, 32'd0);
    check_eq("abort_done", {31'd0, done8}, 32'd0);
    check_eq("abort_res",  {23'd0, cout8, sum8}, 32'd0);
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done8) seen++;
    end
    check_eq("abort_no_done", seen, 32'd0);
    run8(8'h0F, 8'h01, 1'b0, 9'h000, res8, lat, nbusy, hold_bad);
    check_eq("after_abort_res", {23'd0, res8}, 32'h010);

    // start held high, operands changing every cycle
    ndone = 0; last_done = -1; pbusy = 1'b0;
    ea = '0; eb = '0; ec = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      da = 8'($urandom); db = 8'($urandom); dc = 1'($urandom);
      start8 = 1'b1; a8 = da; b8 = db; cin8 = dc;
      @(posedge clk); #1;
      if (busy8 && !pbusy) begin
        ea = da; eb = db; ec = dc;
      end
      if (done8) begin
        ndone++;
        exp8 = {1'b0, ea} + {1'b0, eb} + {8'd0, ec};
        check_eq("stream_res", {23'd0, cout8, sum8}, {23'd0, exp8});
        if (last_done >= 0) check_eq("stream_period", cyc - last_done, 32'd10);
        last_done = cyc;
      end
      pbusy = busy8;
    end
    check_eq("stream_count", ndone, 32'd5);
    @(negedge clk); start8 = 1'b0;
    seen = 0;
    while ((busy8 || done8) && seen < 40) begin
      @(posedge clk); #1;
      seen++;
    end
    @(posedge clk); #1;

    for (int i = 0; i < 1000; i++) begin
      da = 8'($urandom); db = 8'($urandom); dc = 1'($urandom);
      exp8 = {1'b0, da} + {1'b0, db} + {8'd0, dc};
      run8(da, db, dc, {cout8, sum8}, res8, lat, nbusy, hold_bad);
      check_eq("rand8_res", {23'd0, res8}, {23'd0, exp8});
      if (lat != 8) check_eq("rand8_lat", lat, 32'd8);
    end

    run4(4'hF, 4'hF, 1'b1, res4, lat);
    check_eq("w4_max_res", {27'd0, res4}, 32'h1F);
    check_eq("w4_max_lat", lat, 32'd4);
    for (int i = 0; i < 300; i++) begin
      a4 = 4'($urandom);
      exp4 = 5'(a4) + 5'(b4) + 5'(cin4);
      run4(a4, b4, cin4, res4, lat);
      check_eq("rand4_res", {27'd0, res4}, {27'd0, exp4});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
